// File: rtl/montgomery_pkg.sv
// Shared types and sizing helpers for the Montgomery-domain conversion block.
package montgomery_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of RUN cycles that each perform PBITS doublings.
    function automatic int unsigned iters(input int unsigned nbits, input int unsigned pbits);
        return nbits / pbits;
    endfunction

    // Counter must be able to hold ITERS itself (the terminal value).
    function automatic int unsigned cnt_width(input int unsigned nbits, input int unsigned pbits);
        return $clog2(iters(nbits, pbits) + 1);
    endfunction

endpackage

// File: rtl/montgomery_to_conv_mod_double_step.sv
// One modular doubling: (2*x) mod m, valid while x < m.
module mod_double_step #(
    parameter int unsigned NBITS = 2048
) (
    input  logic [NBITS-1:0] x,
    input  logic [NBITS-1:0] m,
    output logic [NBITS-1:0] dbl_c
);

    logic [NBITS:0] t;
    logic [NBITS:0] m_ext;
    logic [NBITS:0] diff;

    assign t     = {x, 1'b0};
    assign m_ext = {1'b0, m};
    assign diff  = t - m_ext;
    assign dbl_c = (t >= m_ext) ? diff[NBITS-1:0] : t[NBITS-1:0];

endmodule

// File: rtl/montgomery_to_conv.sv
// Converts a into the Montgomery domain (a * 2^NBITS mod m) by repeated modular doubling.
module montgomery_to_conv
    import montgomery_pkg::*;
#(
    parameter int unsigned NBITS = 2048,
    parameter int unsigned PBITS = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable_p,
    input  logic [NBITS-1:0] a,
    input  logic [NBITS-1:0] m,
    output logic [NBITS-1:0] y,
    output logic             done_irq_p,
    output logic             busy
);

    localparam int unsigned ITERS = iters(NBITS, PBITS);
    localparam int unsigned CW    = cnt_width(NBITS, PBITS);

    if (NBITS % PBITS != 0) begin : g_bad_pbits
        $error("montgomery_to_conv: NBITS must be a multiple of PBITS");
    end

    state_t           state;
    state_t           state_n;
    logic [CW-1:0]    cnt;
    logic [NBITS-1:0] r;
    logic [NBITS-1:0] m_q;
    logic [NBITS-1:0] chain [PBITS+1];

    // PBITS doublings chained combinationally per clock.
    assign chain[0] = r;
    for (genvar i = 0; i < PBITS; i++) begin : g_step
        mod_double_step #(.NBITS(NBITS)) u_step (
            .x     (chain[i]),
            .m     (m_q),
            .dbl_c (chain[i+1])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // After ITERS stepping cycles, one extra RUN cycle hands r over to y on DONE entry.
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (enable_p) state_n = RUN;
            RUN:     if (cnt == CW'(ITERS)) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r          <= '0;
            m_q        <= '0;
            cnt        <= '0;
            y          <= '0;
            busy       <= 1'b0;
            done_irq_p <= 1'b0;
        end else begin
            busy       <= (state_n != IDLE);
            done_irq_p <= (state_n == DONE);
            unique case (state)
                IDLE: begin
                    if (enable_p) begin
                        r   <= a;
                        m_q <= m;
                        cnt <= '0;
                    end
                end
                RUN: begin
                    if (cnt != CW'(ITERS)) begin
                        r   <= chain[PBITS];
                        cnt <= cnt + CW'(1);
                    end else begin
                        y <= (m_q == '0) ? '0 : r;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_montgomery_to_conv.sv
// Directed and randomised checks of montgomery_to_conv across four parameterisations.
module tb_montgomery_to_conv;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic [7:0]    a8, m8;
    logic [2047:0] aw, mw;
    logic [3:0]    en;
    logic [3:0]    done;
    logic [3:0]    busy;
    logic [7:0]    y81, y84;
    logic [2047:0] yw1, yw8;

    int errors = 0;
    int checks = 0;

    montgomery_to_conv #(.NBITS(8), .PBITS(1)) u_n1 (
        .clk(clk), .rst_n(rst_n), .enable_p(en[0]), .a(a8), .m(m8),
        .y(y81), .done_irq_p(done[0]), .busy(busy[0]));
    montgomery_to_conv #(.NBITS(8), .PBITS(4)) u_n4 (
        .clk(clk), .rst_n(rst_n), .enable_p(en[1]), .a(a8), .m(m8),
        .y(y84), .done_irq_p(done[1]), .busy(busy[1]));
    montgomery_to_conv #(.NBITS(2048), .PBITS(1)) u_w1 (
        .clk(clk), .rst_n(rst_n), .enable_p(en[2]), .a(aw), .m(mw),
        .y(yw1), .done_irq_p(done[2]), .busy(busy[2]));
    montgomery_to_conv #(.NBITS(2048), .PBITS(8)) u_w8 (
        .clk(clk), .rst_n(rst_n), .enable_p(en[3]), .a(aw), .m(mw),
        .y(yw8), .done_irq_p(done[3]), .busy(busy[3]));

    typedef struct {
        logic [7:0] a;
        logic [7:0] m;
        logic [7:0] y;
    } vec_t;

    function automatic logic [2047:0] yget(input int s);
        case (s)
            0:       return 2048'(y81);
            1:       return 2048'(y84);
            2:       return yw1;
            default: return yw8;
        endcase
    endfunction

    function automatic int lat_of(input int s);
        case (s)
            0:       return 9;
            1:       return 3;
            2:       return 2049;
            default: return 257;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [2047:0] act, input logic [2047:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act[127:0], exp[127:0]);
        end
    endtask

    // Starts one conversion on DUT s and checks latency, busy, y stability and result.
    task automatic run_op(input int s, input logic [2047:0] av, input logic [2047:0] mv,
                          input logic [2047:0] ev, input string nm);
        int lat;
        bit seen, bad_busy, bad_y;
        logic [2047:0] yprev;
        lat = lat_of(s);
        @(negedge clk);
        a8 = av[7:0]; m8 = mv[7:0]; aw = av; mw = mv;
        en[s] = 1'b1;
        yprev = yget(s);
        @(posedge clk); #1;
        en = '0;
        seen = 0; bad_busy = 0; bad_y = 0;
        for (int k = 1; k <= lat + 4 && !seen; k++) begin
            @(posedge clk); #1;
            if (busy[s] !== 1'b1) bad_busy = 1;
            if (done[s] === 1'b1) begin
                seen = 1;
                chk({nm, " latency"}, 2048'(k), 2048'(lat));
                chk({nm, " y"}, yget(s), ev);
            end else if (yget(s) !== yprev) begin
                bad_y = 1;
            end
        end
        if (!seen) chk({nm, " done timeout"}, 2048'(0), 2048'(1));
        chk({nm, " busy during op"}, 2048'(bad_busy), 2048'(0));
        chk({nm, " y stable in run"}, 2048'(bad_y), 2048'(0));
        @(posedge clk); #1;
        chk({nm, " idle after done"}, 2048'({busy[s], done[s]}), 2048'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t          tbl [10];
        logic [2047:0] ra, rm, re;
        logic [4095:0] num;
        int            pulses;
        bit            bad;
        logic [7:0]    ycap;

        tbl[0] = '{a: 8'd5,   m: 8'd13,  y: 8'd6};
        tbl[1] = '{a: 8'd12,  m: 8'd13,  y: 8'd4};
        tbl[2] = '{a: 8'd254, m: 8'd255, y: 8'd254};
        tbl[3] = '{a: 8'd0,   m: 8'd255, y: 8'd0};
        tbl[4] = '{a: 8'd7,   m: 8'd13,  y: 8'd11};
        tbl[5] = '{a: 8'd250, m: 8'd251, y: 8'd246};
        tbl[6] = '{a: 8'd2,   m: 8'd3,   y: 8'd2};
        tbl[7] = '{a: 8'd100, m: 8'd129, y: 8'd58};
        tbl[8] = '{a: 8'd0,   m: 8'd1,   y: 8'd0};
        tbl[9] = '{a: 8'd0,   m: 8'd0,   y: 8'd0};

        en = '0; a8 = '0; m8 = '0; aw = '0; mw = '0;
        #2 rst_n = 1'b0;
        #1;
        chk("reset y n1", yget(0), '0);
        chk("reset y w8", yget(3), '0);
        chk("reset busy/done", 2048'({busy, done}), '0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_op(0, 2048'(tbl[i].a), 2048'(tbl[i].m), 2048'(tbl[i].y), $sformatf("vec%0d p1", i));
            run_op(1, 2048'(tbl[i].a), 2048'(tbl[i].m), 2048'(tbl[i].y), $sformatf("vec%0d p4", i));
        end

        // Second enable mid-run is ignored: one pulse, original result.
        @(negedge clk); a8 = 8'd5; m8 = 8'd13; en[0] = 1'b1;
        @(posedge clk); #1; en[0] = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); a8 = 8'd7; en[0] = 1'b1;
        @(negedge clk); en[0] = 1'b0;
        pulses = 0; ycap = '0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (done[0] === 1'b1) begin pulses++; ycap = y81; end
        end
        chk("midrun enable pulses", 2048'(pulses), 2048'(1));
        chk("midrun enable y", 2048'(ycap), 2048'(6));
        run_op(0, 2048'(7), 2048'(13), 2048'(11), "restart a7");

        // Input changes during RUN, then enable on the DONE cycle.
        @(negedge clk); a8 = 8'd12; m8 = 8'd13; en[0] = 1'b1;
        @(posedge clk); #1; en[0] = 1'b0;
        @(negedge clk); a8 = 8'd3; m8 = 8'd11;
        pulses = 0;
        for (int k = 0; k < 20 && pulses == 0; k++) begin
            @(posedge clk); #1;
            if (done[0] === 1'b1) pulses = 1;
        end
        chk("input change done seen", 2048'(pulses), 2048'(1));
        chk("input change y", 2048'(y81), 2048'(4));
        en[0] = 1'b1;
        @(posedge clk); #1; en[0] = 1'b0;
        bad = 0;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk); #1;
            if (done[0] !== 1'b0 || busy[0] !== 1'b0) bad = 1;
        end
        chk("enable on done ignored", 2048'(bad), 2048'(0));

        // Asynchronous reset in the middle of RUN.
        @(negedge clk); a8 = 8'd5; m8 = 8'd13; en[0] = 1'b1;
        @(posedge clk); #1; en[0] = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset y", 2048'(y81), '0);
        chk("async reset busy/done", 2048'({busy[0], done[0]}), '0);
        @(negedge clk) rst_n = 1'b1;
        bad = 0;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk); #1;
            if (done[0] !== 1'b0) bad = 1;
        end
        chk("no done after reset", 2048'(bad), 2048'(0));
        run_op(0, 2048'(5), 2048'(13), 2048'(6), "after reset");

        // Wide operands against the direct reference a*2^2048 mod m.
        rm = '1; ra = rm - 2048'(1);
        run_op(3, ra, rm, ra, "wide m=R-1");
        for (int i = 0; i < 8; i++) begin
            for (int w = 0; w < 64; w++) begin
                rm[w*32 +: 32] = $urandom;
                ra[w*32 +: 32] = $urandom;
            end
            rm[0] = 1'b1;
            if (i % 2 == 1) rm = rm >> (i * 131);
            ra  = ra % rm;
            num = {ra, 2048'b0};
            re  = 2048'(num % {2048'b0, rm});
            run_op((i < 6) ? 3 : 2, ra, rm, re, $sformatf("wide rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
